// File: rtl/iter_mult_32.sv
`default_nettype none
// ============================================================================
// Module   : iter_mult_32
// Purpose  : 32x32 signed radix-2 Booth multiplier, one add/sub per cycle.
//            Define ITER_MULT_OVF_EN to enable the signed-overflow flag.
// Revision : 1.0 - initial release
// ============================================================================

module iter_mult_32_rca #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
);
   logic [WIDTH:0] w_c;

   assign w_c[0] = i_cin;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
         assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
      end
   endgenerate

   assign o_cout = w_c[WIDTH];
endmodule

module iter_mult_32 #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [5:0]         r_count;
   logic [WIDTH-1:0]   r_mcand;
   logic [2*WIDTH:0]   r_prod;     // {P_hi, P_lo, q_-1}

   logic [WIDTH-1:0]   w_phi;
   logic [WIDTH-1:0]   w_addend;
   logic               w_cin;
   logic [WIDTH-1:0]   w_sum;
   logic               w_cout;
   logic               w_sum_msb;
   logic [2*WIDTH:0]   w_next;
   logic               w_ovf;

   assign w_phi = r_prod[2*WIDTH:WIDTH+1];

   always_comb begin
      w_addend = '0;
      w_cin    = 1'b0;
      case (r_prod[1:0])
         2'b01: w_addend = r_mcand;
         2'b10: begin
            w_addend = ~r_mcand;
            w_cin    = 1'b1;
         end
         default: ;
      endcase
   end

   iter_mult_32_rca #(.WIDTH(WIDTH)) u_rca (
      .i_a    (w_phi),
      .i_b    (w_addend),
      .i_cin  (w_cin),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // 33rd sum bit from the sign extensions keeps a -2^31 subtraction exact
   assign w_sum_msb = w_phi[WIDTH-1] ^ w_addend[WIDTH-1] ^ w_cout;
   assign w_next    = {w_sum_msb, w_sum, r_prod[WIDTH:1]};

`ifdef ITER_MULT_OVF_EN
   assign w_ovf = (w_next[2*WIDTH:WIDTH+1] != {WIDTH{w_next[WIDTH]}});
`else
   assign w_ovf = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= IDLE;
         r_count        <= '0;
         r_mcand        <= '0;
         r_prod         <= '0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         if (ctrl_MULT) begin
            r_mcand <= data_operandA;
            r_prod  <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
            r_count <= '0;
            r_state <= BUSY;
         end else begin
            case (r_state)
               BUSY: begin
                  r_prod  <= w_next;
                  r_count <= r_count + 6'd1;
                  if (r_count == 6'(WIDTH - 1)) begin
                     data_result    <= w_next[WIDTH:1];
                     data_exception <= w_ovf;
                     data_resultRDY <= 1'b1;
                     r_state        <= DONE;
                  end
               end
               DONE:    r_state <= IDLE;
               default: r_state <= IDLE;
            endcase
         end
      end
   end
endmodule

`default_nettype wire
